// File: rtl/ref_mem_ring.sv
// Ring buffer of reference rows for a sliding search window, with 1-cycle
// burst (NROW rows) and single-row reads addressed relative to the oldest row.
module ref_mem_ring #(
   parameter int PIXEL = 8,
   parameter int X     = 32,
   parameter int DEPTH = 64,
   parameter int NROW  = 8,
   parameter int AW    = $clog2(DEPTH),
   parameter int SW    = $clog2(NROW)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [X*PIXEL-1:0]        ref_input,
   input  logic                      wr_en,
   input  logic                      beg_en,
   input  logic                      slide_en,
   input  logic [AW-1:0]             rd_address,
   input  logic                      rd8R_en,
   input  logic                      rd1R_en,
   input  logic [SW-1:0]             rdR_sel,
   output logic [NROW*X*PIXEL-1:0]   ref_8R_32,
   output logic                      Oda8R_va,
   output logic [X*PIXEL-1:0]        ref_1R,
   output logic                      da1R_va,
   output logic [AW:0]               fill_cnt,
   output logic                      full,
   output logic                      empty,
   output logic                      rd_err
);

   localparam int RW = X * PIXEL;
   localparam logic [AW:0]   DEPTH_V = (AW+1)'(DEPTH);
   localparam logic [AW+1:0] NROW_V  = (AW+2)'(NROW);

   logic [RW-1:0]      mem_q [DEPTH];
   logic [AW-1:0]      wr_ptr_q, wr_ptr_d, base_ptr_q, base_ptr_d;
   logic [AW:0]        fill_q, fill_d;
   logic               full_q, full_d, empty_q, empty_d;
   logic [NROW*RW-1:0] ref8_q, ref8_d;
   logic [RW-1:0]      ref1_q, ref1_d;
   logic               va8_q, va8_d, va1_q, va1_d, err_q, err_d;

   logic               wr_acc_s, sl_acc_s, mem_we_s;
   logic [AW-1:0]      mem_wa_s, rd_base_s;
   logic               burst_ok_s, single_ok_s;
   logic [NROW*RW-1:0] burst_data_s;
   logic [RW-1:0]      single_data_s;

   // Acceptance, pointer/fill next state and read muxing, all on pre-update state
   always_comb begin
      sl_acc_s      = slide_en && !empty_q;
      // A write while full is accepted only when a slide frees a row this cycle
      wr_acc_s      = wr_en && (!full_q || sl_acc_s);
      burst_ok_s    = ({2'b00, rd_address} + NROW_V) <= {1'b0, fill_q};
      single_ok_s   = ({2'b00, rd_address} + (AW+2)'(rdR_sel)) < {1'b0, fill_q};
      rd_base_s     = base_ptr_q + rd_address;
      burst_data_s  = {(NROW*RW){1'b0}};
      for (int k = 0; k < NROW; k++) begin
         burst_data_s[k*RW +: RW] = mem_q[rd_base_s + AW'(k)];
      end
      single_data_s = mem_q[rd_base_s + AW'(rdR_sel)];

      mem_we_s   = 1'b0;
      mem_wa_s   = wr_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      base_ptr_d = base_ptr_q;
      fill_d     = fill_q;
      if (beg_en) begin
         mem_we_s   = wr_en;
         mem_wa_s   = {AW{1'b0}};
         wr_ptr_d   = wr_en ? AW'(1) : {AW{1'b0}};
         base_ptr_d = {AW{1'b0}};
         fill_d     = wr_en ? (AW+1)'(1) : {(AW+1){1'b0}};
      end else begin
         mem_we_s   = wr_acc_s;
         mem_wa_s   = wr_ptr_q;
         wr_ptr_d   = wr_acc_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
         base_ptr_d = sl_acc_s ? base_ptr_q + AW'(1) : base_ptr_q;
         if (wr_acc_s && !sl_acc_s) begin
            fill_d = fill_q + (AW+1)'(1);
         end else if (!wr_acc_s && sl_acc_s) begin
            fill_d = fill_q - (AW+1)'(1);
         end else begin
            fill_d = fill_q;
         end
      end
      full_d  = (fill_d == DEPTH_V);
      empty_d = (fill_d == {(AW+1){1'b0}});

      va8_d  = rd8R_en && burst_ok_s;
      va1_d  = rd1R_en && single_ok_s;
      err_d  = (rd8R_en && !burst_ok_s) || (rd1R_en && !single_ok_s);
      ref8_d = va8_d ? burst_data_s : ref8_q;
      ref1_d = va1_d ? single_data_s : ref1_q;
   end

   // Row storage; contents survive reset but reset blocks a same-cycle write
   always_ff @(posedge clk) begin
      if (mem_we_s && !rst) begin
         mem_q[mem_wa_s] <= ref_input;
      end
   end

   // Pointer, status and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q   <= {AW{1'b0}};
         base_ptr_q <= {AW{1'b0}};
         fill_q     <= {(AW+1){1'b0}};
         full_q     <= 1'b0;
         empty_q    <= 1'b1;
         ref8_q     <= {(NROW*RW){1'b0}};
         ref1_q     <= {RW{1'b0}};
         va8_q      <= 1'b0;
         va1_q      <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         base_ptr_q <= base_ptr_d;
         fill_q     <= fill_d;
         full_q     <= full_d;
         empty_q    <= empty_d;
         ref8_q     <= ref8_d;
         ref1_q     <= ref1_d;
         va8_q      <= va8_d;
         va1_q      <= va1_d;
         err_q      <= err_d;
      end
   end

   assign ref_8R_32 = ref8_q;
   assign Oda8R_va  = va8_q;
   assign ref_1R    = ref1_q;
   assign da1R_va   = va1_q;
   assign fill_cnt  = fill_q;
   assign full      = full_q;
   assign empty     = empty_q;
   assign rd_err    = err_q;

endmodule
